// File: rtl/gray_rank_filter.sv
// gray_rank_filter: 3x3 rank-order (median / min / max) filter for a gray pixel stream.
// Fixed 4-cycle latency; border, oversize-line and bypass-mode pixels pass through raw.
module gray_rank_filter #(
    parameter int         DATA_WIDTH   = 8,
    parameter int         IMG_H_PIXEL  = 1024,
    parameter logic [1:0] MODE_DEFAULT = 2'd1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic                  per_frame_vsync,
    input  logic                  per_frame_href,
    input  logic                  per_frame_clken,
    input  logic [DATA_WIDTH-1:0] per_img_Y,
    output logic                  post_frame_vsync,
    output logic                  post_frame_href,
    output logic                  post_frame_clken,
    output logic [DATA_WIDTH-1:0] post_img_Y,
    output logic                  err_line_long
);
    localparam int COL_W = (IMG_H_PIXEL > 1) ? $clog2(IMG_H_PIXEL) : 1;
    localparam int ROW_W = 16;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_H_PIXEL - 1);

    typedef logic [DATA_WIDTH-1:0] pix_t;

    function automatic pix_t min2(input pix_t a, input pix_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic pix_t max2(input pix_t a, input pix_t b);
        return (a < b) ? b : a;
    endfunction

    function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
        return min2(min2(a, b), c);
    endfunction

    function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
        return max2(max2(a, b), c);
    endfunction

    function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    logic             vsync_q, href_q;
    logic [COL_W-1:0] col;
    logic             col_full;
    logic [ROW_W-1:0] row;
    logic             frame_ok;
    logic [1:0]       mode_r;

    logic vs_rise, href_fall, pix_en, ovf, win_ok;
    assign vs_rise   = per_frame_vsync & ~vsync_q;
    assign href_fall = ~per_frame_href & href_q;
    assign pix_en    = per_frame_clken & per_frame_href;
    assign ovf       = pix_en & col_full;
    // col_full marks that the last legal column has been consumed on this line
    assign win_ok    = frame_ok && (mode_r != 2'd0) && (row > ROW_W'(1)) &&
                       (col > COL_W'(1)) && !col_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q       <= 1'b1;
            href_q        <= 1'b0;
            col           <= '0;
            col_full      <= 1'b0;
            row           <= '0;
            frame_ok      <= 1'b0;
            mode_r        <= MODE_DEFAULT;
            err_line_long <= 1'b0;
        end else begin
            vsync_q <= per_frame_vsync;
            href_q  <= per_frame_href;
            if (!per_frame_href) begin
                col      <= '0;
                col_full <= 1'b0;
            end else if (per_frame_clken) begin
                if (col == COL_MAX) col_full <= 1'b1;
                else                col      <= col + 1'b1;
            end
            if (vs_rise)                         row <= '0;
            else if (href_fall && (row != '1))   row <= row + 1'b1;
            if (vs_rise) begin
                frame_ok <= 1'b1;
                mode_r   <= mode;
            end
            if (ovf)          err_line_long <= 1'b1;
            else if (vs_rise) err_line_long <= 1'b0;
        end
    end

    pix_t lb1 [IMG_H_PIXEL];
    pix_t lb2 [IMG_H_PIXEL];
    pix_t lb1_rd, lb2_rd;
    assign lb1_rd = lb1[col];
    assign lb2_rd = lb2[col];

    always_ff @(posedge clk) begin
        if (pix_en && !col_full) begin
            lb1[col] <= per_img_Y;
            lb2[col] <= lb1_rd;
        end
    end

    // Sync delay lines: always shifting, vld_pN doubles as the pipeline stage enable
    logic vld_p0, vld_p1, vld_p2;
    logic vs_p0, vs_p1, vs_p2, hs_p0, hs_p1, hs_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            {vld_p0, vld_p1, vld_p2, post_frame_clken} <= '0;
            {vs_p0, vs_p1, vs_p2, post_frame_vsync}    <= '0;
            {hs_p0, hs_p1, hs_p2, post_frame_href}     <= '0;
        end else begin
            {vld_p0, vld_p1, vld_p2, post_frame_clken} <= {per_frame_clken, vld_p0, vld_p1, vld_p2};
            {vs_p0, vs_p1, vs_p2, post_frame_vsync}    <= {per_frame_vsync, vs_p0, vs_p1, vs_p2};
            {hs_p0, hs_p1, hs_p2, post_frame_href}     <= {per_frame_href, hs_p0, hs_p1, hs_p2};
        end
    end

    // Stage 0: window capture; rows 0/1/2 = r-2/r-1/r, column 2 newest
    pix_t       win_p0 [3][3];
    pix_t       raw_p0;
    logic       byp_p0;
    logic [1:0] mode_p0;

    always_ff @(posedge clk) begin
        if (per_frame_clken) begin
            for (int i = 0; i < 3; i++) begin
                win_p0[i][0] <= win_p0[i][1];
                win_p0[i][1] <= win_p0[i][2];
            end
            win_p0[0][2] <= lb2_rd;
            win_p0[1][2] <= lb1_rd;
            win_p0[2][2] <= per_img_Y;
            raw_p0       <= per_img_Y;
            byp_p0       <= !win_ok;
            mode_p0      <= mode_r;
        end
    end

    // Stage 1: sort each window row
    pix_t       min_p1 [3];
    pix_t       mid_p1 [3];
    pix_t       max_p1 [3];
    pix_t       raw_p1;
    logic       byp_p1;
    logic [1:0] mode_p1;

    always_ff @(posedge clk) begin
        if (vld_p0) begin
            for (int i = 0; i < 3; i++) begin
                min_p1[i] <= min3(win_p0[i][0], win_p0[i][1], win_p0[i][2]);
                mid_p1[i] <= med3(win_p0[i][0], win_p0[i][1], win_p0[i][2]);
                max_p1[i] <= max3(win_p0[i][0], win_p0[i][1], win_p0[i][2]);
            end
            raw_p1  <= raw_p0;
            byp_p1  <= byp_p0;
            mode_p1 <= mode_p0;
        end
    end

    // Stage 2: cross-row reductions
    pix_t       maxmin_p2, midmid_p2, minmax_p2, minmin_p2, maxmax_p2;
    pix_t       raw_p2;
    logic       byp_p2;
    logic [1:0] mode_p2;

    always_ff @(posedge clk) begin
        if (vld_p1) begin
            maxmin_p2 <= max3(min_p1[0], min_p1[1], min_p1[2]);
            midmid_p2 <= med3(mid_p1[0], mid_p1[1], mid_p1[2]);
            minmax_p2 <= min3(max_p1[0], max_p1[1], max_p1[2]);
            minmin_p2 <= min3(min_p1[0], min_p1[1], min_p1[2]);
            maxmax_p2 <= max3(max_p1[0], max_p1[1], max_p1[2]);
            raw_p2    <= raw_p1;
            byp_p2    <= byp_p1;
            mode_p2   <= mode_p1;
        end
    end

    // Stage 3: final select into the output register, zero between strobes
    always_ff @(posedge clk) begin
        if (rst || !vld_p2) begin
            post_img_Y <= '0;
        end else if (byp_p2) begin
            post_img_Y <= raw_p2;
        end else begin
            case (mode_p2)
                2'd2:    post_img_Y <= minmin_p2;
                2'd3:    post_img_Y <= maxmax_p2;
                default: post_img_Y <= med3(maxmin_p2, midmid_p2, minmax_p2);
            endcase
        end
    end

endmodule

// File: tb/tb_gray_rank_filter.sv
// tb_gray_rank_filter: directed frames with random pixels/strobe gaps, checked every cycle
// against an image-level reference (3x3 neighbourhood sort) and frame-level sync/flag model.
module tb_gray_rank_filter;
    localparam int W = 8;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'd1;
    logic       per_frame_vsync = 1'b0;
    logic       per_frame_href = 1'b0;
    logic       per_frame_clken = 1'b0;
    logic [7:0] per_img_Y = 8'h00;
    logic       post_frame_vsync, post_frame_href, post_frame_clken, err_line_long;
    logic [7:0] post_img_Y;

    always #5 clk = ~clk;

    gray_rank_filter #(
        .DATA_WIDTH  (8),
        .IMG_H_PIXEL (W),
        .MODE_DEFAULT(2'd1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mode            (mode),
        .per_frame_vsync (per_frame_vsync),
        .per_frame_href  (per_frame_href),
        .per_frame_clken (per_frame_clken),
        .per_img_Y       (per_img_Y),
        .post_frame_vsync(post_frame_vsync),
        .post_frame_href (post_frame_href),
        .post_frame_clken(post_frame_clken),
        .post_img_Y      (post_img_Y),
        .err_line_long   (err_line_long)
    );

    typedef struct packed {
        logic       vs;
        logic       hs;
        logic       ce;
        logic [7:0] y;
    } exp_t;

    exp_t       exp_at [8192];
    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;
    logic       err_exp = 1'b0;
    logic       frame_ok_m = 1'b0;
    logic [1:0] frame_mode_m = 2'd1;
    logic       prev_vs = 1'b0;
    logic [7:0] img [H][W+2];
    logic [7:0] obs_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Expected output for pixel (r,c) of the current frame
    function automatic logic [7:0] model_px(input int r, input int c);
        logic [7:0] s [9];
        logic [7:0] t;
        int k;
        if (!frame_ok_m || frame_mode_m == 2'd0 || r < 2 || c < 2 || c >= W)
            return img[r][c];
        k = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                s[k] = img[r-2+i][c-2+j];
                k++;
            end
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8; j++)
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
        case (frame_mode_m)
            2'd2:    return s[0];
            2'd3:    return s[8];
            default: return s[4];
        endcase
    endfunction

    task automatic cycle(input logic r, input logic vs, input logic hs, input logic ce,
                         input logic [7:0] y, input logic [7:0] ey, input bit ovf);
        exp_t e;
        @(negedge clk);
        e = exp_at[cyc];
        chk("post_vsync", post_frame_vsync, e.vs);
        chk("post_href", post_frame_href, e.hs);
        chk("post_clken", post_frame_clken, e.ce);
        chk("post_img_Y", post_img_Y, e.y);
        chk("err_line_long", err_line_long, err_exp);
        if (post_frame_clken === 1'b1) obs_q.push_back(post_img_Y);
        rst = r;
        per_frame_vsync = vs;
        per_frame_href = hs;
        per_frame_clken = ce;
        per_img_Y = y;
        if (r) begin
            for (int i = 1; i <= 4; i++) exp_at[cyc+i] = '0;
            err_exp = 1'b0;
            frame_ok_m = 1'b0;
            frame_mode_m = 2'd1;
        end else begin
            exp_at[cyc+4] = {vs, hs, ce, (ce ? ey : 8'h00)};
            if (ovf)                 err_exp = 1'b1;
            else if (vs && !prev_vs) err_exp = 1'b0;
            if (vs && !prev_vs) begin
                frame_ok_m = 1'b1;
                frame_mode_m = mode;
            end
        end
        prev_vs = vs;
        cyc++;
    endtask

    task automatic idle(input int n, input logic vs);
        repeat (n) cycle(1'b0, vs, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic fill(input int kind);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W + 2; c++)
                case (kind)
                    0:       img[r][c] = 8'h40;
                    1:       img[r][c] = (r == 3 && c == 3) ? 8'hFF : 8'h10;
                    2:       img[r][c] = 8'(c * 16);
                    default: img[r][c] = 8'($urandom_range(0, 255));
                endcase
    endtask

    task automatic send_frame(input int ovf_row, input int chg_row, input logic [1:0] chg_val,
                              input int rst_row, input bit gaps);
        int   ncols, c;
        bit   rst_done;
        logic ce;
        obs_q.delete();
        rst_done = 1'b0;
        idle(2, 1'b1);
        idle(3, 1'b0);
        for (int r = 0; r < H; r++) begin
            if (r == chg_row) mode = chg_val;
            ncols = (r == ovf_row) ? W + 2 : W;
            c = 0;
            while (c < ncols) begin
                if (r == rst_row && c == 3 && !rst_done) begin
                    cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
                    rst_done = 1'b1;
                    #6;
                    chk("rst_mode_default", dut.mode_r, 2'd1);
                    chk("rst_post_Y_zero", post_img_Y, 8'h00);
                    chk("rst_post_href_zero", post_frame_href, 1'b0);
                    chk("rst_err_zero", err_line_long, 1'b0);
                end else begin
                    ce = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                    if (ce) begin
                        cycle(1'b0, 1'b0, 1'b1, 1'b1, img[r][c], model_px(r, c), c >= W);
                        c++;
                    end else begin
                        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
                    end
                end
            end
            idle(3, 1'b0);
        end
        idle(6, 1'b0);
    endtask

    function automatic int count_val(input logic [7:0] v);
        int n = 0;
        foreach (obs_q[k]) if (obs_q[k] === v) n++;
        return n;
    endfunction

    function automatic int raw_mismatches(input int first, input int last);
        int n = 0;
        for (int k = first; k <= last; k++)
            if (k >= obs_q.size() || obs_q[k] !== img[k / W][k % W]) n++;
        return n;
    endfunction

    initial begin
        foreach (exp_at[i]) exp_at[i] = '0;
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("reset_post_Y", post_img_Y, 8'h00);
        chk("reset_post_clken", post_frame_clken, 1'b0);
        chk("reset_err", err_line_long, 1'b0);

        // flat frame, median
        fill(0); mode = 2'd1;
        send_frame(-1, -1, 2'd0, -1, 1'b0);
        chk("flat_count_40", count_val(8'h40), 64);

        // impulse: median suppresses, max spreads to nine outputs
        fill(1); mode = 2'd1;
        send_frame(-1, -1, 2'd0, -1, 1'b1);
        chk("impulse_median_ff", count_val(8'hFF), 0);
        mode = 2'd3;
        send_frame(-1, -1, 2'd0, -1, 1'b1);
        chk("impulse_max_ff", count_val(8'hFF), 9);

        // ramp: min at center column 4, then bypass
        fill(2); mode = 2'd2;
        send_frame(-1, -1, 2'd0, -1, 1'b0);
        chk("ramp_min_center4", obs_q[3*W+5], 8'h30);
        mode = 2'd0;
        send_frame(-1, -1, 2'd0, -1, 1'b1);
        chk("ramp_bypass_raw", raw_mismatches(0, H*W-1), 0);

        // mid-frame mode change only lands at the next frame
        fill(1); mode = 2'd1;
        send_frame(-1, 1, 2'd3, -1, 1'b0);
        chk("modechg_still_median", count_val(8'hFF), 0);
        send_frame(-1, -1, 2'd0, -1, 1'b0);
        chk("modechg_next_max", count_val(8'hFF), 9);

        // over-long last line raises the sticky flag, next vsync clears it
        fill(3); mode = 2'd1;
        send_frame(H-1, -1, 2'd0, -1, 1'b1);
        chk("err_after_long_line", err_line_long, 1'b1);
        chk("long_frame_pixels", obs_q.size(), H*W + 2);
        fill(3);
        send_frame(-1, -1, 2'd0, -1, 1'b0);
        chk("err_cleared_next_frame", err_line_long, 1'b0);

        // reset mid-line: remainder raw, then fresh frame raw in rows 0-1
        fill(3); mode = 2'd3;
        send_frame(-1, -1, 2'd0, 4, 1'b1);
        fill(3);
        send_frame(-1, -1, 2'd0, -1, 1'b0);
        chk("post_rst_rows01_raw", raw_mismatches(0, 2*W-1), 0);

        repeat (3) begin
            fill(3);
            mode = 2'($urandom_range(0, 3));
            send_frame(-1, -1, 2'd0, -1, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
